simple_single_cpu: RTL and testbench

- Single-cycle 32-bit MIPS-subset processor, used as the top of the lab CPU.
- Each rising clock edge fetches, decodes, executes and writes back exactly one instruction.
- Contains its own instruction memory (preloaded by the bench) and a 32-entry register file.
- No data memory. Benches inspect the instruction memory and register file through fixed hierarchical names.

---
 rtl/simple_single_cpu_pkg.sv | 34 +++
 rtl/simple_single_cpu_instr_mem.sv | 28 ++
 rtl/simple_single_cpu_reg_file.sv | 35 +++
 rtl/simple_single_cpu.sv | 153 +++++++++++++++
 tb/tb_simple_single_cpu.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_single_cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-subset CPU:
// opcode/funct encodings, ALU control enum and word width.
package simple_single_cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SRAV = 6'h07;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SRA
    } alu_op_e;

    function automatic logic [WORD_W-1:0] sext16(input logic [15:0] v);
        return {{(WORD_W-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/simple_single_cpu_instr_mem.sv
// Instruction memory: asynchronous word read, optional load port.
// Ports: clk, we/waddr/wdata (load), raddr -> rdata (fetch).
module simple_single_cpu_instr_mem
    import simple_single_cpu_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] Instr_Mem [0:DEPTH-1];

    // Contents survive reset, so no reset branch here.
    always_ff @(posedge clk) begin
        if (we) begin
            Instr_Mem[waddr] <= wdata;
        end
    end

    assign rdata = Instr_Mem[raddr];

endmodule

// File: rtl/simple_single_cpu_reg_file.sv
// Register file: two combinational read ports, one edge write port.
// Ports: clk, rst_n, we/waddr/wdata, raddr_a/b -> rdata_a/b. r0 is hardwired 0.
module simple_single_cpu_reg_file
    import simple_single_cpu_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [4:0]        raddr_a,
    input  logic [4:0]        raddr_b,
    output logic [WORD_W-1:0] rdata_a,
    output logic [WORD_W-1:0] rdata_b
);

    logic [WORD_W-1:0] Reg_File [0:DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                Reg_File[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            Reg_File[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not visible.
    assign rdata_a = (raddr_a == 5'd0) ? '0 : Reg_File[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : Reg_File[raddr_b];

endmodule

// File: rtl/simple_single_cpu.sv
// Single-cycle MIPS-subset CPU: fetch, decode, execute, writeback per edge.
// Ports: clk_i (rising-edge clock), rst_i (async active-low reset).
module simple_single_cpu
    import simple_single_cpu_pkg::*;
#(
    parameter int IM_DEPTH = 32,
    parameter int RF_DEPTH = 32
) (
    input  logic clk_i,
    input  logic rst_i
);

    localparam int IM_AW = $clog2(IM_DEPTH);

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] br_target;
    logic [WORD_W-1:0] pc_next;
    logic [WORD_W-1:0] instr;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [WORD_W-1:0] simm;

    alu_op_e     alu_op;
    logic        reg_we;
    logic        dst_rt;
    logic        use_imm;
    logic        shift_var;
    logic        is_beq;
    logic        is_bne;
    logic        take;

    logic [WORD_W-1:0] rs_data;
    logic [WORD_W-1:0] rt_data;
    logic [WORD_W-1:0] src_b;
    logic [4:0]        sh_amt;
    logic [WORD_W-1:0] alu_res;
    logic [4:0]        waddr;

    // Word index wraps naturally by taking only the low index bits.
    simple_single_cpu_instr_mem #(
        .DEPTH (IM_DEPTH)
    ) IM (
        .clk   (clk_i),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (pc[IM_AW+1:2]),
        .rdata (instr)
    );

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign simm  = sext16(instr[15:0]);

    always_comb begin
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        dst_rt    = 1'b0;
        use_imm   = 1'b0;
        shift_var = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    F_ADD:  begin reg_we = 1'b1; alu_op = ALU_ADD; end
                    F_SUB:  begin reg_we = 1'b1; alu_op = ALU_SUB; end
                    F_AND:  begin reg_we = 1'b1; alu_op = ALU_AND; end
                    F_OR:   begin reg_we = 1'b1; alu_op = ALU_OR;  end
                    F_SLT:  begin reg_we = 1'b1; alu_op = ALU_SLT; end
                    F_SRA:  begin reg_we = 1'b1; alu_op = ALU_SRA; end
                    F_SRAV: begin
                        reg_we    = 1'b1;
                        alu_op    = ALU_SRA;
                        shift_var = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                reg_we  = 1'b1;
                dst_rt  = 1'b1;
                use_imm = 1'b1;
            end
            OP_SLTI: begin
                reg_we  = 1'b1;
                dst_rt  = 1'b1;
                use_imm = 1'b1;
                alu_op  = ALU_SLT;
            end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            default: ;
        endcase
    end

    simple_single_cpu_reg_file #(
        .DEPTH (RF_DEPTH)
    ) RF (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .we      (reg_we),
        .waddr   (waddr),
        .wdata   (alu_res),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_data),
        .rdata_b (rt_data)
    );

    assign waddr  = dst_rt ? rt : rd;
    assign src_b  = use_imm ? simm : rt_data;
    assign sh_amt = shift_var ? rs_data[4:0] : shamt;

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            ALU_ADD: alu_res = rs_data + src_b;
            ALU_SUB: alu_res = rs_data - src_b;
            ALU_AND: alu_res = rs_data & src_b;
            ALU_OR:  alu_res = rs_data | src_b;
            ALU_SLT: alu_res = {31'd0, $signed(rs_data) < $signed(src_b)};
            ALU_SRA: alu_res = $signed(rt_data) >>> sh_amt;
            default: alu_res = '0;
        endcase
    end

    assign take = (is_beq && (rs_data == rt_data)) ||
                  (is_bne && (rs_data != rt_data));

    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {simm[29:0], 2'b00};
    assign pc_next   = take ? br_target : pc_plus4;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_simple_single_cpu.sv
// Self-checking bench for simple_single_cpu: directed programs plus random
// programs checked each cycle against an instruction-level interpreter.
module tb_simple_single_cpu;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] prog  [32];
    logic [31:0] m_reg [32];
    logic [31:0] m_pc;

    simple_single_cpu #(
        .IM_DEPTH (32),
        .RF_DEPTH (32)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int fn, input int rs,
                                          input int rt, input int rd,
                                          input int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs,
                                          input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 32'd0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) dut.IM.Instr_Mem[i] <= prog[i];
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    endtask

    // Interprets one instruction from the ISA rules.
    task automatic model_step();
        logic [31:0] w, a, b, simm, res;
        int op, fn, rs, rt, rd, sh;
        bit wr;
        int dst;
        w    = prog[(m_pc / 4) % 32];
        op   = int'(w[31:26]);
        rs   = int'(w[25:21]);
        rt   = int'(w[20:16]);
        rd   = int'(w[15:11]);
        sh   = int'(w[10:6]);
        fn   = int'(w[5:0]);
        a    = m_reg[rs];
        b    = m_reg[rt];
        simm = {{16{w[15]}}, w[15:0]};
        wr   = 0;
        dst  = rd;
        res  = 32'd0;
        m_pc = m_pc + 4;
        if (op == 0) begin
            wr = 1;
            case (fn)
                'h20: res = a + b;
                'h22: res = a - b;
                'h24: res = a & b;
                'h25: res = a | b;
                'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                'h03: res = $signed(b) >>> sh;
                'h07: res = $signed(b) >>> a[4:0];
                default: wr = 0;
            endcase
        end else if (op == 'h08) begin
            wr = 1; dst = rt; res = a + simm;
        end else if (op == 'h0A) begin
            wr = 1; dst = rt;
            res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
        end else if ((op == 'h04 && a == b) || (op == 'h05 && a != b)) begin
            m_pc = m_pc + simm * 4;
        end
        if (wr && dst != 0) m_reg[dst] = res;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_pc"}, dut.pc, m_pc);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_r%0d", tag, i), dut.RF.Reg_File[i], m_reg[i]);
    endtask

    // Holds reset across one rising edge, then releases between edges.
    task automatic start(input string tag);
        rst_i = 1'b0;
        load_prog();
        @(negedge clk_i);
        model_reset();
        compare_all({tag, "_rst"});
        rst_i = 1'b1;
    endtask

    task automatic run(input string tag, input int n);
        repeat (n) begin
            @(negedge clk_i);
            model_step();
            compare_all(tag);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int k, rs, rt, rd;
        k  = int'($urandom_range(0, 12));
        rs = int'($urandom_range(0, 7));
        rt = int'($urandom_range(0, 7));
        rd = int'($urandom_range(0, 7));
        case (k)
            0: return enc_r('h20, rs, rt, rd, 0);
            1: return enc_r('h22, rs, rt, rd, 0);
            2: return enc_r('h24, rs, rt, rd, 0);
            3: return enc_r('h25, rs, rt, rd, 0);
            4: return enc_r('h2A, rs, rt, rd, 0);
            5: return enc_r('h03, 0, rt, rd, int'($urandom_range(0, 31)));
            6: return enc_r('h07, rs, rt, rd, 0);
            7, 8, 9: return enc_i('h08, rs, rt, int'($urandom_range(0, 65535)));
            10: return enc_i('h0A, rs, rt, int'($urandom_range(0, 65535)));
            11: return enc_i($urandom_range(0, 1) ? 'h04 : 'h05, rs, rt,
                             int'($urandom_range(0, 6)) - 3);
            default: return $urandom_range(0, 1) ? 32'hFC00_0000
                                                 : enc_r('h3F, rs, rt, rd, 0);
        endcase
    endfunction

    initial begin
        // Reset and first instruction
        clear_prog();
        prog[0] = enc_i('h08, 0, 1, 5);
        start("first");
        run("first", 1);
        check("first_r1", dut.RF.Reg_File[1], 32'd5);
        check("first_pc", dut.pc, 32'd4);

        // Arithmetic chain
        clear_prog();
        prog[0] = enc_i('h08, 0, 1, 7);
        prog[1] = enc_i('h08, 0, 2, 3);
        prog[2] = enc_r('h22, 1, 2, 3, 0);
        prog[3] = enc_r('h20, 1, 2, 4, 0);
        prog[4] = enc_r('h2A, 2, 1, 5, 0);
        prog[5] = enc_i('h0A, 1, 6, -1);
        start("chain");
        run("chain", 6);
        check("chain_r3", dut.RF.Reg_File[3], 32'd4);
        check("chain_r4", dut.RF.Reg_File[4], 32'd10);
        check("chain_r5", dut.RF.Reg_File[5], 32'd1);
        check("chain_r6", dut.RF.Reg_File[6], 32'd0);

        // Shifts and logic
        clear_prog();
        prog[0] = enc_i('h08, 0, 2, -16);
        prog[1] = enc_i('h08, 0, 3, 2);
        prog[2] = enc_r('h07, 3, 2, 4, 0);
        prog[3] = enc_r('h03, 0, 2, 5, 4);
        prog[4] = enc_r('h24, 2, 3, 6, 0);
        prog[5] = enc_r('h25, 2, 3, 7, 0);
        start("shift");
        run("shift", 6);
        check("shift_r4", dut.RF.Reg_File[4], 32'hFFFF_FFFC);
        check("shift_r5", dut.RF.Reg_File[5], 32'hFFFF_FFFF);
        check("shift_r6", dut.RF.Reg_File[6], 32'd0);
        check("shift_r7", dut.RF.Reg_File[7], 32'hFFFF_FFF2);

        // Branches
        clear_prog();
        prog[0] = enc_i('h08, 0, 1, 1);
        prog[1] = enc_i('h04, 1, 1, 1);
        prog[2] = enc_i('h08, 0, 2, 9);
        prog[3] = enc_i('h05, 1, 0, 1);
        prog[4] = enc_i('h08, 0, 3, 9);
        prog[5] = enc_i('h08, 0, 4, 2);
        start("branch");
        run("branch", 4);
        check("branch_pc", dut.pc, 32'd24);
        check("branch_r2", dut.RF.Reg_File[2], 32'd0);
        check("branch_r3", dut.RF.Reg_File[3], 32'd0);
        check("branch_r4", dut.RF.Reg_File[4], 32'd2);

        // r0 and NOP handling
        clear_prog();
        prog[0] = enc_i('h08, 0, 0, 5);
        prog[1] = 32'hFC00_0000;
        prog[2] = enc_i('h08, 0, 1, 1);
        start("nop");
        run("nop", 3);
        check("nop_r0", dut.RF.Reg_File[0], 32'd0);
        check("nop_r1", dut.RF.Reg_File[1], 32'd1);

        // Asynchronous reset mid-run, then restart from word 0
        clear_prog();
        prog[0] = enc_i('h08, 0, 1, 7);
        prog[1] = enc_i('h08, 0, 2, 3);
        prog[2] = enc_r('h22, 1, 2, 3, 0);
        prog[3] = enc_r('h20, 1, 2, 4, 0);
        prog[4] = enc_r('h2A, 2, 1, 5, 0);
        prog[5] = enc_i('h0A, 1, 6, -1);
        start("mid");
        run("mid", 3);
        #2 rst_i = 1'b0;
        #1;
        check("mid_async_pc", dut.pc, 32'd0);
        check("mid_async_r3", dut.RF.Reg_File[3], 32'd0);
        model_reset();
        compare_all("mid_async");
        @(negedge clk_i);
        compare_all("mid_hold");
        rst_i = 1'b1;
        run("restart", 6);
        check("restart_r3", dut.RF.Reg_File[3], 32'd4);
        check("restart_r4", dut.RF.Reg_File[4], 32'd10);

        // Random programs, including PC wrap past the last word
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 32; i++) prog[i] = rand_instr();
            start($sformatf("rnd%0d", t));
            run($sformatf("rnd%0d", t), 45);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
